// File: rtl/diners_pkg.sv
// Shared dining-philosophers types, ring-neighbour helpers and defaults.
package diners_pkg;

   typedef enum logic [1:0] {
      THINKING = 2'd0,
      HUNGRY   = 2'd1,
      EATING   = 2'd2,
      READING  = 2'd3
   } t_state;

   localparam int unsigned DEFAULT_STARVE_LIMIT = 7;
   localparam int unsigned DEFAULT_MAX_MEAL     = 4;
   localparam int unsigned WAIT_CNT_W           = 8;

   function automatic int unsigned left_of(input int unsigned i, input int unsigned n);
      return (i == 0) ? n - 1 : i - 1;
   endfunction

   function automatic int unsigned right_of(input int unsigned i, input int unsigned n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/dining_seat_ctrl.sv
// One seat: THINKING/HUNGRY/EATING state, wait counter and starvation alarm.
// DINING_WAITER_MEAL_TIMEOUT_EN adds a meal counter with forced release.
module dining_seat_ctrl
   import diners_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
   ,
   parameter int unsigned MAX_MEAL = DEFAULT_MAX_MEAL
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hungry_i,
   input  logic done_i,
   input  logic nbr_eat_i,
   input  logic win_i,
   output logic req_c,
   output logic eat_d_c,
   output logic eat_o,
   output logic alarm_o
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
   ,
   output logic timeout_o
`endif
);

   localparam int unsigned WAIT_W = WAIT_CNT_W;

   t_state            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              eat_q, alarm_q;

`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
   localparam int unsigned MEAL_W = (MAX_MEAL > 1) ? $clog2(MAX_MEAL) : 1;
   logic [MEAL_W-1:0] meal_q, meal_d;
   logic              timeout_q, timeout_d;
`endif

   // A seat may compete only while still requesting and with both forks free.
   assign req_c   = (state_q == HUNGRY) && hungry_i && !nbr_eat_i;
   assign eat_d_c = (state_d == EATING);
   assign eat_o   = eat_q;
   assign alarm_o = alarm_q;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
      meal_d    = meal_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         THINKING: begin
            if (hungry_i) begin
               state_d = HUNGRY;
               wait_d  = '0;
            end
         end
         HUNGRY: begin
            if (!hungry_i) begin
               state_d = THINKING;
               wait_d  = '0;
            end else if (win_i) begin
               state_d = EATING;
               wait_d  = '0;
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
               meal_d  = '0;
`endif
            end else if (wait_q < WAIT_W'(STARVE_LIMIT)) begin
               wait_d = wait_q + 1'b1;
            end
         end
         EATING: begin
            if (done_i) begin
               state_d = THINKING;
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
            end else if (meal_q == MEAL_W'(MAX_MEAL - 1)) begin
               state_d   = THINKING;
               timeout_d = 1'b1;
            end else begin
               meal_d = meal_q + 1'b1;
`endif
            end
         end
         default: state_d = THINKING;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= THINKING;
         wait_q  <= '0;
         eat_q   <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         eat_q   <= (state_d == EATING);
         alarm_q <= (wait_d == WAIT_W'(STARVE_LIMIT));
      end
   end

`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
   assign timeout_o = timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meal_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         meal_q    <= meal_d;
         timeout_q <= timeout_d;
      end
   end
`endif

endmodule

// File: rtl/dining_waiter.sv
// Fork-ring waiter: round-robin grants, no adjacent eaters, per-seat starvation alarm.
// DINING_WAITER_MEAL_TIMEOUT_EN enables forced release after MAX_MEAL cycles (timeout_evt).
module dining_waiter
   import diners_pkg::*;
#(
   parameter int unsigned N_SEATS      = 3,
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int unsigned MAX_MEAL     = DEFAULT_MAX_MEAL,
   parameter int unsigned PTR_W        = $clog2(N_SEATS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_SEATS-1:0] hungry,
   input  logic [N_SEATS-1:0] done,
   output logic [N_SEATS-1:0] grant,
   output logic [N_SEATS-1:0] fork_busy,
   output logic [N_SEATS-1:0] starve_alarm,
   output logic [PTR_W-1:0]   rr_ptr
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
   ,
   output logic [N_SEATS-1:0] timeout_evt
`endif
);

   if (N_SEATS < 2 || N_SEATS > 16 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || MAX_MEAL < 1)
   begin : g_bad_params
      $error("dining_waiter: illegal parameter set");
   end

   logic [N_SEATS-1:0] req_c, win_c, eat_d_c, eat_q, nbr_eat_c, alarm_q, fork_d_c;
   logic [N_SEATS-1:0] fork_busy_q;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   int unsigned        best_c, win_seat_c, dist_c;

   for (genvar s = 0; s < N_SEATS; s++) begin : g_seat
      assign nbr_eat_c[s] = eat_q[left_of(s, N_SEATS)] | eat_q[right_of(s, N_SEATS)];
      assign fork_d_c[s]  = eat_d_c[s] | eat_d_c[left_of(s, N_SEATS)];

      dining_seat_ctrl #(
         .STARVE_LIMIT(STARVE_LIMIT)
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
         ,
         .MAX_MEAL    (MAX_MEAL)
`endif
      ) u_seat (
         .clk      (clk),
         .rst_n    (rst_n),
         .hungry_i (hungry[s]),
         .done_i   (done[s]),
         .nbr_eat_i(nbr_eat_c[s]),
         .win_i    (win_c[s]),
         .req_c    (req_c[s]),
         .eat_d_c  (eat_d_c[s]),
         .eat_o    (eat_q[s]),
         .alarm_o  (alarm_q[s])
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
         ,
         .timeout_o(timeout_evt[s])
`endif
      );
   end

   // Winner is the requesting seat at the smallest ring distance from rr_ptr.
   always_comb begin
      best_c     = N_SEATS;
      win_seat_c = 0;
      dist_c     = 0;
      win_c      = '0;
      for (int unsigned s = 0; s < N_SEATS; s++) begin
         dist_c = (s + N_SEATS - 32'(rr_ptr_q)) % N_SEATS;
         if (req_c[s] && dist_c < best_c) begin
            best_c     = dist_c;
            win_seat_c = s;
         end
      end
      for (int unsigned s = 0; s < N_SEATS; s++) begin
         win_c[s] = (best_c < N_SEATS) && (win_seat_c == s);
      end
      rr_ptr_d = (best_c < N_SEATS) ? PTR_W'((win_seat_c + 1) % N_SEATS) : rr_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         fork_busy_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         fork_busy_q <= fork_d_c;
      end
   end

   assign grant        = eat_q;
   assign fork_busy    = fork_busy_q;
   assign starve_alarm = alarm_q;
   assign rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_dining_waiter.sv
// Bench for dining_waiter: directed scenarios plus random traffic against a seat-level model.
module tb_dining_waiter;

   localparam int N     = 3;
   localparam int LIMIT = 7;
   localparam int MAXM  = 4;
   localparam int PW    = 2;
   localparam int T = 0, H = 1, E = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  hungry = '0;
   logic [N-1:0]  done = '0;
   logic [N-1:0]  grant, fork_busy, starve_alarm;
   logic [PW-1:0] rr_ptr;
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
   logic [N-1:0]  timeout_evt;
`endif

   int checks = 0;
   int errors = 0;

   int st[N];
   int wt[N];
   int ml[N];
   int m_rr;
   logic [N-1:0] m_to;

   dining_waiter #(.N_SEATS(N), .STARVE_LIMIT(LIMIT), .MAX_MEAL(MAXM)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hungry      (hungry),
      .done        (done),
      .grant       (grant),
      .fork_busy   (fork_busy),
      .starve_alarm(starve_alarm),
      .rr_ptr      (rr_ptr)
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
      ,
      .timeout_evt (timeout_evt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic logic [N-1:0] m_grant();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (st[i] == E);
      return r;
   endfunction

   function automatic logic [N-1:0] m_busy();
      logic [N-1:0] r;
      for (int j = 0; j < N; j++) r[j] = (st[j] == E) || (st[(j + N - 1) % N] == E);
      return r;
   endfunction

   function automatic logic [N-1:0] m_alarm();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (wt[i] == LIMIT);
      return r;
   endfunction

   task automatic model_step();
      int win;
      int nst[N];
      int nwt[N];
      int nml[N];
      logic [N-1:0] nto;
      win = -1;
      nto = '0;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (win < 0 && st[i] == H && hungry[i] && st[(i + N - 1) % N] != E && st[(i + 1) % N] != E)
            win = i;
      end
      for (int i = 0; i < N; i++) begin
         nst[i] = st[i];
         nwt[i] = wt[i];
         nml[i] = ml[i];
         if (st[i] == T) begin
            if (hungry[i]) begin nst[i] = H; nwt[i] = 0; end
         end else if (st[i] == H) begin
            if (!hungry[i]) begin nst[i] = T; nwt[i] = 0; end
            else if (i == win) begin nst[i] = E; nwt[i] = 0; nml[i] = 0; end
            else if (wt[i] < LIMIT) nwt[i] = wt[i] + 1;
         end else begin
            if (done[i]) nst[i] = T;
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
            else if (ml[i] == MAXM - 1) begin nst[i] = T; nto[i] = 1'b1; end
            else nml[i] = ml[i] + 1;
`endif
         end
      end
      for (int i = 0; i < N; i++) begin
         st[i] = nst[i];
         wt[i] = nwt[i];
         ml[i] = nml[i];
      end
      m_to = nto;
      if (win >= 0) m_rr = (win + 1) % N;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin st[i] = T; wt[i] = 0; ml[i] = 0; end
         m_to = '0;
         m_rr = 0;
      end else begin
         model_step();
      end
   end

   // Every cycle out of reset the DUT must match the model and keep neighbours apart.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("grant", 32'(grant), 32'(m_grant()));
         chk("fork_busy", 32'(fork_busy), 32'(m_busy()));
         chk("starve_alarm", 32'(starve_alarm), 32'(m_alarm()));
         chk("rr_ptr", 32'(rr_ptr), 32'(m_rr));
         chk("adjacent", 32'(grant & {grant[0], grant[N-1:1]}), 32'd0);
`ifdef DINING_WAITER_MEAL_TIMEOUT_EN
         chk("timeout_evt", 32'(timeout_evt), 32'(m_to));
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_fork_busy", 32'(fork_busy), 32'd0);
      chk("rst_rr_ptr", 32'(rr_ptr), 32'd0);
      hungry = '0;
      done   = '0;
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("init_grant", 32'(grant), 32'd0);
      chk("init_alarm", 32'(starve_alarm), 32'd0);
      chk("init_rr_ptr", 32'(rr_ptr), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick(); chk("idle_grant_1", 32'(grant), 32'd0);
      tick(); chk("idle_grant_2", 32'(grant), 32'd0);

      // Everyone hungry at once: seat 0 first, then seat 1 one edge after the release.
      hungry = 3'b111;
      tick(); chk("sim_e1_grant", 32'(grant), 32'd0);
      tick(); chk("sim_e2_grant", 32'(grant), 32'b001);
              chk("sim_e2_rr", 32'(rr_ptr), 32'd1);
      tick(); chk("sim_e3_grant", 32'(grant), 32'b001);
      done = 3'b001;
      tick(); chk("sim_e4_grant", 32'(grant), 32'b000);
              chk("sim_e4_busy", 32'(fork_busy), 32'b000);
      done = 3'b000;
      tick(); chk("sim_e5_grant", 32'(grant), 32'b010);
              chk("sim_e5_busy", 32'(fork_busy), 32'b110);
              chk("sim_e5_rr", 32'(rr_ptr), 32'd2);

      async_reset();

      // Seat 0 eats on, seat 1 starves until seat 0 lets go.
      hungry = 3'b011;
      tick();
      tick(); chk("stv_e2_grant", 32'(grant), 32'b001);
      repeat (5) tick();
      chk("stv_e7_alarm", 32'(starve_alarm), 32'b000);
      tick(); chk("stv_e8_alarm", 32'(starve_alarm), 32'b010);
      done = 3'b001;
      tick(); chk("stv_e9_grant", 32'(grant), 32'b000);
              chk("stv_e9_alarm", 32'(starve_alarm), 32'b010);
      done = 3'b000;
      tick(); chk("stv_e10_grant", 32'(grant), 32'b010);
              chk("stv_e10_alarm", 32'(starve_alarm), 32'b000);

      async_reset();

      // Seat 2 withdraws while blocked; a stray done is ignored; its count restarts from 0.
      hungry = 3'b001;
      tick();
      tick(); chk("wd_e2_grant", 32'(grant), 32'b001);
      hungry = 3'b101;
      tick();
      tick();
      hungry = 3'b001;
      tick(); chk("wd_e5_grant", 32'(grant), 32'b001);
      done = 3'b100;
      tick(); chk("wd_e6_grant", 32'(grant), 32'b001);
              chk("wd_e6_alarm", 32'(starve_alarm), 32'b000);
      done = 3'b000;
      hungry = 3'b101;
      tick();
      repeat (6) tick();
      chk("wd_e13_alarm", 32'(starve_alarm), 32'b000);
      tick(); chk("wd_e14_alarm", 32'(starve_alarm), 32'b100);

      async_reset();

      // Random traffic with occasional mid-run asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] h, d;
         if (c % 700 == 699) async_reset();
         h = hungry;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) h[i] = ~h[i];
            d[i] = ($urandom_range(0, 3) == 0);
         end
         hungry = h;
         done   = d;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
